iir_coeff_bank: RTL and testbench

IIR_COEFF_BANK -- requirements
Module: iir_coeff_bank

---
 rtl/iir_coeff_bank.sv | 111 +++++++++++
 tb/tb_iir_coeff_bank.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_coeff_bank.sv
// Double-buffered coefficient store for a two-stage biquad cascade.
// Writes land in a shadow set and reach the active set only on a sample boundary.
module iir_coeff_bank #(
    parameter int COEFF_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [3:0]                    wr_addr,
    input  logic signed [COEFF_WIDTH-1:0] wr_data,
    input  logic                          commit_req,
    input  logic                          sample_strobe,
    output logic                          commit_done,
    output logic                          busy,
    output logic [1:0]                    err,
    input  logic                          err_clr,
    output logic signed [COEFF_WIDTH-1:0] b0_1,
    output logic signed [COEFF_WIDTH-1:0] b1_1,
    output logic signed [COEFF_WIDTH-1:0] b2_1,
    output logic signed [COEFF_WIDTH-1:0] a1_1,
    output logic signed [COEFF_WIDTH-1:0] a2_1,
    output logic signed [COEFF_WIDTH-1:0] b0_2,
    output logic signed [COEFF_WIDTH-1:0] b1_2,
    output logic signed [COEFF_WIDTH-1:0] b2_2,
    output logic signed [COEFF_WIDTH-1:0] a1_2,
    output logic signed [COEFF_WIDTH-1:0] a2_2
);

    // 1.0 in Q2.(COEFF_WIDTH-2): passthrough gain for b0 of each stage
    localparam logic signed [COEFF_WIDTH-1:0] UNITY = {2'b01, {(COEFF_WIDTH-2){1'b0}}};

    typedef enum logic [1:0] {LOAD, PENDING, DONE} state_t;

    state_t                          state, state_nxt;
    logic [9:0]                      mask, mask_nxt;
    logic                            wr_acc, wr_bad, commit_bad, apply;
    logic signed [COEFF_WIDTH-1:0]   shadow [10];
    logic signed [COEFF_WIDTH-1:0]   active [10];

    assign wr_ready    = (state == LOAD);
    assign busy        = (state != LOAD);
    assign commit_done = (state == DONE);

    always_comb begin
        wr_acc     = wr_valid && (state == LOAD);
        wr_bad     = wr_acc && (wr_addr > 4'd9);
        mask_nxt   = mask;
        commit_bad = 1'b0;
        apply      = 1'b0;
        state_nxt  = state;
        for (int i = 0; i < 10; i++) begin
            if (wr_acc && (wr_addr == 4'(i))) mask_nxt[i] = 1'b1;
        end
        case (state)
            LOAD: begin
                // commit sees the mask including this cycle's write
                if (commit_req) begin
                    if (&mask_nxt) state_nxt  = PENDING;
                    else           commit_bad = 1'b1;
                end
            end
            PENDING: begin
                if (sample_strobe) begin
                    apply     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
            mask  <= '0;
            err   <= '0;
        end else begin
            state <= state_nxt;
            mask  <= apply ? 10'd0 : mask_nxt;
            err   <= (err & {2{~err_clr}}) | {commit_bad, wr_bad};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 10; i++) begin
                shadow[i] <= (i == 0 || i == 5) ? UNITY : '0;
                active[i] <= (i == 0 || i == 5) ? UNITY : '0;
            end
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (wr_acc && (wr_addr == 4'(i))) shadow[i] <= wr_data;
                if (apply)                        active[i] <= shadow[i];
            end
        end
    end

    assign b0_1 = active[0];
    assign b1_1 = active[1];
    assign b2_1 = active[2];
    assign a1_1 = active[3];
    assign a2_1 = active[4];
    assign b0_2 = active[5];
    assign b1_2 = active[6];
    assign b2_2 = active[7];
    assign a1_2 = active[8];
    assign a2_2 = active[9];

endmodule

// File: tb/tb_iir_coeff_bank.sv
// Directed bench for iir_coeff_bank: reset, full commit, incomplete commit,
// bad addresses, coincident strobe, and reset during a pending commit.
module tb_iir_coeff_bank;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_valid;
    logic               wr_ready;
    logic [3:0]         wr_addr;
    logic signed [15:0] wr_data;
    logic               commit_req;
    logic               sample_strobe;
    logic               commit_done;
    logic               busy;
    logic [1:0]         err;
    logic               err_clr;
    logic signed [15:0] b0_1, b1_1, b2_1, a1_1, a2_1, b0_2, b1_2, b2_2, a1_2, a2_2;

    logic signed [15:0] obs [10];
    logic signed [15:0] exp [10];
    int cmp_cnt  = 0;
    int fail_cnt = 0;

    iir_coeff_bank #(.COEFF_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit_req(commit_req),
        .sample_strobe(sample_strobe), .commit_done(commit_done), .busy(busy),
        .err(err), .err_clr(err_clr),
        .b0_1(b0_1), .b1_1(b1_1), .b2_1(b2_1), .a1_1(a1_1), .a2_1(a2_1),
        .b0_2(b0_2), .b1_2(b1_2), .b2_2(b2_2), .a1_2(a1_2), .a2_2(a2_2)
    );

    always #5 clk = ~clk;

    always_comb begin
        obs[0] = b0_1; obs[1] = b1_1; obs[2] = b2_1; obs[3] = a1_1; obs[4] = a2_1;
        obs[5] = b0_2; obs[6] = b1_2; obs[7] = b2_2; obs[8] = a1_2; obs[9] = a2_2;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] a, input logic signed [15:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic set_exp_passthrough();
        for (int i = 0; i < 10; i++) exp[i] = (i == 0 || i == 5) ? 16'sd16384 : 16'sd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        set_exp_passthrough();
        for (int i = 0; i < 10; i++) begin
            cmp_cnt++;
            if (obs[i] !== exp[i]) begin
                fail_cnt++;
                $display("FAIL reset_out[%0d]: got %0d expected %0d", i, obs[i], exp[i]);
            end
        end
        cmp_cnt++;
        if ({wr_ready, busy, err, commit_done} !== 5'b1_0_00_0) begin
            fail_cnt++;
            $display("FAIL reset_ctrl: got rdy=%b busy=%b err=%b done=%b expected 1 0 00 0",
                     wr_ready, busy, err, commit_done);
        end
    endtask

    task automatic test_commit();
        for (int i = 0; i < 10; i++) write(4'(i), 16'(i + 1));
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        cmp_cnt++;
        if ({wr_ready, busy} !== 2'b01) begin
            fail_cnt++;
            $display("FAIL commit_pending: got rdy=%b busy=%b expected 0 1", wr_ready, busy);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int i = 0; i < 10; i++) begin
                cmp_cnt++;
                if (obs[i] !== exp[i]) begin
                    fail_cnt++;
                    $display("FAIL commit_hold[%0d]: got %0d expected %0d", i, obs[i], exp[i]);
                end
            end
        end
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        for (int i = 0; i < 10; i++) exp[i] = 16'(i + 1);
        for (int i = 0; i < 10; i++) begin
            cmp_cnt++;
            if (obs[i] !== exp[i]) begin
                fail_cnt++;
                $display("FAIL commit_out[%0d]: got %0d expected %0d", i, obs[i], exp[i]);
            end
        end
        cmp_cnt++;
        if ({commit_done, wr_ready, busy} !== 3'b101) begin
            fail_cnt++;
            $display("FAIL commit_done_state: got done=%b rdy=%b busy=%b expected 1 0 1",
                     commit_done, wr_ready, busy);
        end
        tick();
        cmp_cnt++;
        if ({commit_done, wr_ready, busy} !== 3'b010) begin
            fail_cnt++;
            $display("FAIL commit_back_load: got done=%b rdy=%b busy=%b expected 0 1 0",
                     commit_done, wr_ready, busy);
        end
    endtask

    task automatic test_incomplete();
        for (int i = 0; i < 9; i++) write(4'(i), 16'(i + 11));
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        cmp_cnt++;
        if ({err, busy, wr_ready} !== 4'b10_0_1) begin
            fail_cnt++;
            $display("FAIL incomplete_err: got err=%b busy=%b rdy=%b expected 10 0 1", err, busy, wr_ready);
        end
        for (int i = 0; i < 10; i++) begin
            cmp_cnt++;
            if (obs[i] !== exp[i]) begin
                fail_cnt++;
                $display("FAIL incomplete_out[%0d]: got %0d expected %0d", i, obs[i], exp[i]);
            end
        end
        // final write shares the cycle with commit_req and completes the mask
        wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 16'sd20; commit_req = 1'b1;
        tick();
        wr_valid = 1'b0; commit_req = 1'b0;
        cmp_cnt++;
        if (busy !== 1'b1) begin
            fail_cnt++;
            $display("FAIL incomplete_retry: got busy=%b expected 1", busy);
        end
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        for (int i = 0; i < 10; i++) exp[i] = 16'(i + 11);
        for (int i = 0; i < 10; i++) begin
            cmp_cnt++;
            if (obs[i] !== exp[i]) begin
                fail_cnt++;
                $display("FAIL retry_out[%0d]: got %0d expected %0d", i, obs[i], exp[i]);
            end
        end
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        cmp_cnt++;
        if (err !== 2'b00) begin
            fail_cnt++;
            $display("FAIL incomplete_clr: got err=%b expected 00", err);
        end
    endtask

    task automatic test_bad_addr();
        write(4'd12, 16'sh7FFF);
        cmp_cnt++;
        if (err !== 2'b01) begin
            fail_cnt++;
            $display("FAIL bad_addr_err: got err=%b expected 01", err);
        end
        for (int i = 0; i < 10; i++) begin
            cmp_cnt++;
            if (obs[i] !== exp[i]) begin
                fail_cnt++;
                $display("FAIL bad_addr_out[%0d]: got %0d expected %0d", i, obs[i], exp[i]);
            end
        end
        err_clr = 1'b1;
        write(4'd15, 16'sh1234);
        err_clr = 1'b0;
        cmp_cnt++;
        if (err !== 2'b01) begin
            fail_cnt++;
            $display("FAIL bad_addr_set_wins: got err=%b expected 01", err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        cmp_cnt++;
        if (err !== 2'b00) begin
            fail_cnt++;
            $display("FAIL bad_addr_clr: got err=%b expected 00", err);
        end
        // mask was cleared by the last commit and bad writes must not fill it
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        cmp_cnt++;
        if ({err, busy} !== 3'b10_0) begin
            fail_cnt++;
            $display("FAIL bad_addr_mask: got err=%b busy=%b expected 10 0", err, busy);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_coincident();
        for (int i = 0; i < 9; i++) write(4'(i), 16'(-(i + 1)));
        wr_valid = 1'b1; wr_addr = 4'd9; wr_data = -16'sd10;
        commit_req = 1'b1; sample_strobe = 1'b1;
        tick();
        wr_valid = 1'b0; sample_strobe = 1'b0;
        cmp_cnt++;
        if ({busy, commit_done} !== 2'b10) begin
            fail_cnt++;
            $display("FAIL coinc_no_commit: got busy=%b done=%b expected 1 0", busy, commit_done);
        end
        for (int i = 0; i < 10; i++) begin
            cmp_cnt++;
            if (obs[i] !== exp[i]) begin
                fail_cnt++;
                $display("FAIL coinc_hold[%0d]: got %0d expected %0d", i, obs[i], exp[i]);
            end
        end
        tick();
        commit_req = 1'b0;
        repeat (3) tick();
        cmp_cnt++;
        if ({busy, err, commit_done} !== 4'b1_00_0) begin
            fail_cnt++;
            $display("FAIL coinc_pending_hold: got busy=%b err=%b done=%b expected 1 00 0",
                     busy, err, commit_done);
        end
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        for (int i = 0; i < 10; i++) exp[i] = 16'(-(i + 1));
        for (int i = 0; i < 10; i++) begin
            cmp_cnt++;
            if (obs[i] !== exp[i]) begin
                fail_cnt++;
                $display("FAIL coinc_out[%0d]: got %0d expected %0d", i, obs[i], exp[i]);
            end
        end
        cmp_cnt++;
        if (commit_done !== 1'b1) begin
            fail_cnt++;
            $display("FAIL coinc_done: got %b expected 1", commit_done);
        end
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        cmp_cnt++;
        if ({commit_done, busy, err} !== 4'b0_0_00) begin
            fail_cnt++;
            $display("FAIL coinc_done_ignores_req: got done=%b busy=%b err=%b expected 0 0 00",
                     commit_done, busy, err);
        end
    endtask

    task automatic test_reset_pending();
        for (int i = 0; i < 10; i++) write(4'(i), 16'(100 + i));
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        cmp_cnt++;
        if (busy !== 1'b1) begin
            fail_cnt++;
            $display("FAIL rstp_pending: got busy=%b expected 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        set_exp_passthrough();
        for (int i = 0; i < 10; i++) begin
            cmp_cnt++;
            if (obs[i] !== exp[i]) begin
                fail_cnt++;
                $display("FAIL rstp_out[%0d]: got %0d expected %0d", i, obs[i], exp[i]);
            end
        end
        cmp_cnt++;
        if ({busy, commit_done, wr_ready} !== 3'b001) begin
            fail_cnt++;
            $display("FAIL rstp_ctrl: got busy=%b done=%b rdy=%b expected 0 0 1", busy, commit_done, wr_ready);
        end
        sample_strobe = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            sample_strobe = 1'b0;
            cmp_cnt++;
            if ({commit_done, busy} !== 2'b00) begin
                fail_cnt++;
                $display("FAIL rstp_no_done[%0d]: got done=%b busy=%b expected 0 0", c, commit_done, busy);
            end
        end
        for (int i = 0; i < 10; i++) begin
            cmp_cnt++;
            if (obs[i] !== exp[i]) begin
                fail_cnt++;
                $display("FAIL rstp_after[%0d]: got %0d expected %0d", i, obs[i], exp[i]);
            end
        end
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        cmp_cnt++;
        if ({err, busy} !== 3'b10_0) begin
            fail_cnt++;
            $display("FAIL rstp_mask_clear: got err=%b busy=%b expected 10 0", err, busy);
        end
    endtask

    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        commit_req = 1'b0; sample_strobe = 1'b0; err_clr = 1'b0;
        test_reset();
        test_commit();
        test_incomplete();
        test_bad_addr();
        test_coincident();
        test_reset_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
